// File: rtl/bcd_conv_sched_pkg.sv
// Shared constants and types for the time-shared BCD converter scheduler.
// FSM encoding, conversion ranges and the default year-requester mask.
package bcd_conv_sched_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam int YEAR_BASE = 2000;
   localparam int YEAR_MAX  = 3999;
   localparam int FIELD_MAX = 999;

   localparam logic [5:0] DEF_YEAR_MASK = 6'b100000;

   typedef struct packed {
      logic [3:0] thou;
      logic [3:0] hund;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   function automatic logic in_range(input int v, input logic yr);
      if (yr)
         return (v >= YEAR_BASE) && (v <= YEAR_MAX);
      return (v >= 0) && (v <= FIELD_MAX);
   endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/response and converter bundle between the field counters,
// the scheduler and the shared binary-to-BCD converter.
interface bcd_conv_sched_if #(
   parameter int NREQ = 6,
   parameter int W    = 12,
   parameter int IDW  = 3
);

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_val;
   logic [NREQ-1:0]   ack;
   logic [W-1:0]      conv_bin;
   logic [3:0]        conv_thou;
   logic [3:0]        conv_hund;
   logic [3:0]        conv_tens;
   logic [3:0]        conv_ones;
   logic [15:0]       bcd_out;
   logic [IDW-1:0]    out_id;
   logic              out_valid;
   logic              out_err;
   logic              busy;

   modport slave (
      input  req, req_val,
      input  conv_thou, conv_hund, conv_tens, conv_ones,
      output ack, conv_bin,
      output bcd_out, out_id, out_valid, out_err, busy
   );

   modport master (
      output req, req_val,
      output conv_thou, conv_hund, conv_tens, conv_ones,
      input  ack, conv_bin,
      input  bcd_out, out_id, out_valid, out_err, busy
   );

endinterface

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Rotating-priority picker: first request at or after i_ptr, wrapping.
// Purely combinational; the pointer lives in the parent.
module bcd_conv_sched_rr_arbiter #(
   parameter int NREQ = 6,
   parameter int IDW  = 3
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic            o_any,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      int j;
      o_any = 1'b0;
      o_gnt = '0;
      o_idx = '0;
      j     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(i_ptr) + k;
         if (j >= NREQ)
            j = j - NREQ;
         if (i_req[IW'(j)]) begin
            o_any           = 1'b1;
            o_gnt           = '0;
            o_gnt[IW'(j)]   = 1'b1;
            o_idx           = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter between
// the clock field counters, with range checking and +2000 field offset.
module bcd_conv_sched
   import bcd_conv_sched_pkg::*;
#(
   parameter int              NREQ      = 6,
   parameter int              W         = 12,
   parameter logic [NREQ-1:0] YEAR_MASK = NREQ'(DEF_YEAR_MASK),
   parameter int              IDW       = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   bcd_conv_sched_if.slave   bus
);

   logic [1:0]      r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [W-1:0]    r_val;
   logic            r_year;
   logic            r_err;
   bcd_t            r_dig;
   logic [W-1:0]    r_conv_bin;
   logic [NREQ-1:0] r_ack;
   logic [15:0]     r_bcd_out;
   logic [IDW-1:0]  r_out_id;
   logic            r_valid;
   logic            r_out_err;

   logic            w_any;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic [W-1:0]    w_sel;
   logic            w_year;
   logic            w_ok;

   bcd_conv_sched_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   // One-hot grant selects the value, so no index arithmetic is needed.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_gnt[i])
            w_sel = w_sel | bus.req_val[i*W +: W];
   end

   assign w_year = |(w_gnt & YEAR_MASK);
   assign w_ok   = in_range(int'(w_sel), w_year);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_id       <= '0;
         r_val      <= '0;
         r_year     <= 1'b0;
         r_err      <= 1'b0;
         r_dig      <= '0;
         r_conv_bin <= W'(YEAR_BASE);
         r_ack      <= '0;
         r_bcd_out  <= '0;
         r_out_id   <= '0;
         r_valid    <= 1'b0;
         r_out_err  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ack   <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_id    <= w_idx;
                  r_val   <= w_sel;
                  r_year  <= w_year;
                  r_err   <= !w_ok;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_conv_bin <= r_year ? r_val
                                    : r_val + W'(YEAR_BASE);
               r_state    <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // Offset fields land in 2000..2999; drop the borrowed 2.
               r_dig.thou <= r_year ? bus.conv_thou : 4'd0;
               r_dig.hund <= bus.conv_hund;
               r_dig.tens <= bus.conv_tens;
               r_dig.ones <= bus.conv_ones;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               r_bcd_out <= r_err ? 16'h0000 : r_dig;
               r_out_err <= r_err;
               r_out_id  <= r_id;
               r_valid   <= 1'b1;
               for (int i = 0; i < NREQ; i++)
                  r_ack[i] <= (r_id == IDW'(i));
               r_ptr     <= (int'(r_id) == NREQ - 1) ? '0
                                                      : r_id + 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack       = r_ack;
   assign bus.conv_bin  = r_conv_bin;
   assign bus.bcd_out   = r_bcd_out;
   assign bus.out_id    = r_out_id;
   assign bus.out_valid = r_valid;
   assign bus.out_err   = r_out_err;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: directed literal cases plus randomized
// requesters compared every cycle against a transaction-level model.
module tb_bcd_conv_sched;

   localparam int         NREQ  = 6;
   localparam int         W     = 12;
   localparam int         IDW   = 3;
   localparam logic [5:0] YMASK = 6'b100000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bcd_conv_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bif ();

   bcd_conv_sched #(
      .NREQ      (NREQ),
      .W         (W),
      .YEAR_MASK (YMASK),
      .IDW       (IDW)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bif)
   );

   // Behavioural converter: plain decimal digits of conv_bin.
   int cv;
   always_comb begin
      cv            = int'(bif.conv_bin);
      bif.conv_thou = 4'((cv / 1000) % 10);
      bif.conv_hund = 4'((cv / 100) % 10);
      bif.conv_tens = 4'((cv / 10) % 10);
      bif.conv_ones = 4'(cv % 10);
   end

   int vec = 0;
   int bad = 0;
   int cnt = 0;
   bit auto_drop = 1'b1;

   // Transaction-level model state
   int          g       = -100;
   int          free_at = 0;
   int          m_ptr   = 0;
   int          m_id    = 0;
   int          m_val   = 0;
   bit          m_year  = 1'b0;
   logic [15:0] e_bcd   = 16'h0000;
   int          e_id    = 0;
   bit          e_err   = 1'b0;
   logic [W-1:0] e_conv = 12'd2000;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic bit legal(input int v, input bit yr);
      if (yr) return (v >= 2000) && (v <= 3999);
      return (v >= 0) && (v <= 999);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cnt, act, exp);
      end
   endtask

   // Decide what happens at the coming edge from the current inputs.
   task automatic plan();
      int e;
      int j;
      e = cnt + 1;
      if (rst) begin
         m_ptr   = 0;
         g       = -100;
         free_at = e + 1;
         e_bcd   = 16'h0000;
         e_id    = 0;
         e_err   = 1'b0;
         e_conv  = 12'd2000;
      end else if (e >= free_at && |bif.req) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            j = (m_ptr + k) % NREQ;
            if (bif.req[j]) m_id = j;
         end
         m_val   = int'(bif.req_val[m_id*W +: W]);
         m_year  = YMASK[m_id];
         g       = e;
         free_at = e + 4;
         m_ptr   = (m_id + 1) % NREQ;
      end
   endtask

   task automatic check();
      logic [NREQ-1:0] xa;
      bit xv;
      bit xb;
      xa = '0;
      xv = 1'b0;
      if (g > 0 && cnt == g + 1)
         e_conv = W'(m_year ? m_val : (m_val + 2000) % 4096);
      if (g > 0 && cnt == g + 3) begin
         xv       = 1'b1;
         xa[m_id] = 1'b1;
         e_err    = !legal(m_val, m_year);
         e_bcd    = e_err ? 16'h0000 : to_bcd(m_val);
         e_id     = m_id;
      end
      xb = (g > 0 && cnt >= g && cnt <= g + 2);
      chk("ack", 32'(bif.ack), 32'(xa));
      chk("out_valid", 32'(bif.out_valid), 32'(xv));
      chk("busy", 32'(bif.busy), 32'(xb));
      chk("conv_bin", 32'(bif.conv_bin), 32'(e_conv));
      chk("bcd_out", 32'(bif.bcd_out), 32'(e_bcd));
      chk("out_id", 32'(bif.out_id), 32'(e_id));
      chk("out_err", 32'(bif.out_err), 32'(e_err));
   endtask

   task automatic step();
      plan();
      @(posedge clk);
      cnt++;
      @(negedge clk);
      check();
      if (auto_drop)
         for (int i = 0; i < NREQ; i++)
            if (bif.ack[i]) bif.req[i] = 1'b0;
   endtask

   task automatic wait_ack(output int id, output logic [15:0] b,
                           output bit er, output bit ok);
      ok = 1'b0;
      id = -1;
      b  = 16'hxxxx;
      er = 1'b0;
      for (int n = 0; n < 12 && !ok; n++) begin
         step();
         if (bif.out_valid === 1'b1) begin
            ok = 1'b1;
            id = int'(bif.out_id);
            b  = bif.bcd_out;
            er = bif.out_err;
         end
      end
      if (!ok) begin
         vec++;
         bad++;
         $display("FAIL ack_timeout cyc=%0d got=none want=ack", cnt);
      end
   endtask

   task automatic one(input int idx, input int val,
                      input logic [15:0] xb, input bit xe,
                      input int xc);
      int id;
      logic [15:0] b;
      bit er;
      bit ok;
      bif.req[idx]            = 1'b1;
      bif.req_val[idx*W +: W] = W'(val);
      wait_ack(id, b, er, ok);
      bif.req[idx] = 1'b0;
      chk("lit_id", 32'(id), 32'(idx));
      chk("lit_bcd", 32'(b), 32'(xb));
      chk("lit_err", 32'(er), 32'(xe));
      chk("lit_conv", 32'(bif.conv_bin), 32'(xc));
   endtask

   initial begin
      int id;
      int last;
      logic [15:0] b;
      bit er;
      bit ok;
      int exp_rr[7];
      exp_rr = '{0, 1, 2, 3, 4, 5, 0};

      bif.req     = '0;
      bif.req_val = '0;
      rst = 1'b1;
      step();
      step();
      chk("rst_bcd", 32'(bif.bcd_out), 32'h0);
      chk("rst_conv", 32'(bif.conv_bin), 32'd2000);
      chk("rst_busy", 32'(bif.busy), 32'h0);
      chk("rst_valid", 32'(bif.out_valid), 32'h0);
      rst = 1'b0;

      one(5, 2024, 16'h2024, 1'b0, 2024);
      one(0, 59, 16'h0059, 1'b0, 2059);
      one(5, 1999, 16'h0000, 1'b1, 1999);
      one(0, 1000, 16'h0000, 1'b1, 3000);
      one(5, 3999, 16'h3999, 1'b0, 3999);

      // Everyone held high: rotation from pointer 0, 4-cycle spacing.
      auto_drop = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         bif.req[i]            = 1'b1;
         bif.req_val[i*W +: W] = W'((i == 5) ? 2100 + i : 10 * i + 1);
      end
      last = -1;
      for (int n = 0; n < 7; n++) begin
         wait_ack(id, b, er, ok);
         chk("rr_order", 32'(id), 32'(exp_rr[n]));
         if (last >= 0) chk("rr_spacing", 32'(cnt - last), 32'd4);
         last = cnt;
      end
      bif.req   = '0;
      auto_drop = 1'b1;

      one(2, 123, 16'h0123, 1'b0, 2123);
      bif.req[2] = 1'b1;
      bif.req[4] = 1'b1;
      wait_ack(id, b, er, ok);
      chk("rr_skip2", 32'(id), 32'd4);
      wait_ack(id, b, er, ok);
      chk("rr_then2", 32'(id), 32'd2);
      bif.req = '0;

      // Withdrawn request still completes.
      bif.req[1]        = 1'b1;
      bif.req_val[W +: W] = 12'd33;
      step();
      bif.req[1] = 1'b0;
      wait_ack(id, b, er, ok);
      chk("wd_id", 32'(id), 32'd1);
      chk("wd_bcd", 32'(b), 32'h0033);
      bif.req[1] = 1'b1;
      bif.req[3] = 1'b1;
      wait_ack(id, b, er, ok);
      chk("wd_next", 32'(id), 32'd3);
      wait_ack(id, b, er, ok);
      bif.req = '0;

      // Reset while in CAPTURE.
      bif.req[4]            = 1'b1;
      bif.req_val[4*W +: W] = 12'd12;
      step();
      step();
      rst = 1'b1;
      step();
      rst     = 1'b0;
      bif.req = '0;
      chk("mrst_busy", 32'(bif.busy), 32'h0);
      chk("mrst_bcd", 32'(bif.bcd_out), 32'h0);
      chk("mrst_conv", 32'(bif.conv_bin), 32'd2000);
      chk("mrst_ack", 32'(bif.ack), 32'h0);
      bif.req[0] = 1'b1;
      bif.req[3] = 1'b1;
      wait_ack(id, b, er, ok);
      chk("mrst_ptr", 32'(id), 32'd0);
      wait_ack(id, b, er, ok);
      bif.req = '0;

      // Randomized requesters.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!bif.req[i] && $urandom_range(3) == 0) begin
               bif.req[i] = 1'b1;
               if ($urandom_range(7) == 0)
                  bif.req_val[i*W +: W] = W'($urandom_range(4095));
               else if (YMASK[i])
                  bif.req_val[i*W +: W] = W'($urandom_range(4095, 1900));
               else
                  bif.req_val[i*W +: W] = W'($urandom_range(1100));
            end else if (bif.req[i] && $urandom_range(39) == 0) begin
               bif.req[i] = 1'b0;
            end
            if ($urandom_range(15) == 0)
               bif.req_val[i*W +: W] = W'($urandom_range(4095));
         end
         rst = ($urandom_range(499) == 0);
         step();
      end
      rst = 1'b0;
      bif.req = '0;
      for (int n = 0; n < 6; n++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
